mm2im_tile_scheduler: RTL

Sequencer for the MM2IM mapping subsystem across one transpose-conv layer.
- Walks row_id/tile_id over a configured layer and pulses the mapper start.
- Waits for the mapper snapshot, then hands it to the accumulation unit with a valid/ready handshake.
- Releases the transpose FSM for the tile and waits until all PE columns report done before advancing.
- Sits between the layer-level controller and MM2IM/transpose FSM/accumulation unit.

---
 rtl/mm2im_tile_scheduler.sv | 119 +++++++++++
 1 files changed

// File: rtl/mm2im_tile_scheduler.sv
// mm2im_tile_scheduler: walks the row/tile grid of one transpose-conv layer, sequencing MM2IM, snapshot handoff and the transpose FSM.
// Ports:
//   clk, rst_n                            clock, async active-low reset
//   layer_start, layer_id_in,
//   num_rows, num_tiles                   layer request, latched when accepted in IDLE
//   abort                                 synchronous return to IDLE, indices hold
//   map_start, row_id, tile_id, layer_id  MM2IM start pulse and tile coordinates
//   map_done                              MM2IM snapshot ready
//   snap_valid, snap_ready                snapshot handshake to the accumulation unit
//   tile_go, done_PE                      transpose FSM kick and its PE-done count
//   busy, layer_done, tiles_done, err     status
// Optional: define MM2IM_SCHED_WATCHDOG_EN for a sticky watchdog on the two wait states (err tied 0 otherwise).
module mm2im_tile_scheduler #(
    parameter int NUM_PE      = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        layer_start,
    input  logic [1:0]  layer_id_in,
    input  logic [8:0]  num_rows,
    input  logic [5:0]  num_tiles,
    input  logic        abort,
    output logic        map_start,
    output logic [8:0]  row_id,
    output logic [5:0]  tile_id,
    output logic [1:0]  layer_id,
    input  logic        map_done,
    output logic        snap_valid,
    input  logic        snap_ready,
    output logic        tile_go,
    input  logic [4:0]  done_PE,
    output logic        busy,
    output logic        layer_done,
    output logic [14:0] tiles_done,
    output logic        err
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_MAP, PRESENT, WAIT_PE, ADVANCE, DONE} state_t;
    state_t state, next;
    logic [8:0] rows_q;
    logic [5:0] tiles_q;
    logic last_col, last_tile, timeout;
    assign last_col  = tile_id == tiles_q - 6'd1;
    assign last_tile = last_col && (row_id == rows_q - 9'd1);
`ifdef MM2IM_SCHED_WATCHDOG_EN
    localparam int WW = $clog2(TIMEOUT_CYC + 1);
    logic [WW-1:0] wd_cnt;
    logic waiting;
    assign waiting = state == WAIT_MAP || state == WAIT_PE;
    assign timeout = waiting && wd_cnt == WW'(TIMEOUT_CYC - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
            err    <= 1'b0;
        end else begin
            // restarts from zero on every entry into a wait state
            wd_cnt <= (waiting && next == state) ? wd_cnt + 1'b1 : '0;
            if (state == IDLE && layer_start)
                err <= 1'b0;
            else if (timeout && !abort)
                err <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif
    always_comb begin
        next = state;
        case (state)
            IDLE:     if (layer_start) next = (num_rows == 9'd0 || num_tiles == 6'd0) ? DONE : ISSUE;
            ISSUE:    next = WAIT_MAP;
            WAIT_MAP: if (map_done) next = PRESENT;
            PRESENT:  if (snap_ready) next = WAIT_PE;
            WAIT_PE:  if (done_PE >= 5'(NUM_PE)) next = ADVANCE;
            ADVANCE:  next = last_tile ? DONE : ISSUE;
            DONE:     next = IDLE;
            default:  next = IDLE;
        endcase
        // abort outranks everything; the watchdog outranks normal progress
        if (state != IDLE && (abort || timeout)) next = IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            map_start  <= 1'b0;
            snap_valid <= 1'b0;
            tile_go    <= 1'b0;
            busy       <= 1'b0;
            layer_done <= 1'b0;
            row_id     <= '0;
            tile_id    <= '0;
            layer_id   <= '0;
            tiles_done <= '0;
            rows_q     <= '0;
            tiles_q    <= '0;
        end else begin
            state      <= next;
            // outputs are decoded from the next state so each one is a flop aligned with its state
            map_start  <= next == ISSUE;
            snap_valid <= next == PRESENT;
            tile_go    <= state == PRESENT && next == WAIT_PE;
            busy       <= next != IDLE;
            layer_done <= next == DONE;
            if (state == IDLE && layer_start) begin
                layer_id   <= layer_id_in;
                rows_q     <= num_rows;
                tiles_q    <= num_tiles;
                row_id     <= '0;
                tile_id    <= '0;
                tiles_done <= '0;
            end else if (state == ADVANCE && next != IDLE) begin
                tiles_done <= tiles_done + 15'd1;
                tile_id    <= last_col ? 6'd0 : tile_id + 6'd1;
                row_id     <= last_col ? row_id + 9'd1 : row_id;
            end
        end
    end
endmodule
